// File: rtl/tri_pkg.sv
`default_nettype none
// ============================================================================
// Module : tri_pkg
// Brief  : Shared coordinate, vertex and triangle types for the assembler.
// Rev    : 1.0 - initial release
// ============================================================================
package tri_pkg;

  localparam int PKG_WII   = 8;
  localparam int PKG_WIF   = 8;
  localparam int CW        = PKG_WII + PKG_WIF;
  localparam int NUM_WORDS = 9;
  localparam int IDX_W     = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef logic signed [CW-1:0] coord_t;
  typedef coord_t [2:0] vertex_t;

  typedef struct packed {
    vertex_t a;
    vertex_t b;
    vertex_t c;
  } triangle_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/tri_assembler_if.sv
`default_nettype none
// ============================================================================
// Module : tri_assembler_if
// Brief  : Coordinate input stream and assembled-triangle output channel.
// Rev    : 1.0 - initial release
// ============================================================================
interface tri_assembler_if;
  import tri_pkg::*;

  logic    in_valid;
  logic    in_ready;
  coord_t  in_data;
  logic    in_sop;

  logic    tri_valid;
  logic    tri_ready;
  vertex_t vertex_a;
  vertex_t vertex_b;
  vertex_t vertex_c;

  modport slave (
    input  in_valid, in_data, in_sop, tri_ready,
    output in_ready, tri_valid, vertex_a, vertex_b, vertex_c
  );

  modport master (
    output in_valid, in_data, in_sop, tri_ready,
    input  in_ready, tri_valid, vertex_a, vertex_b, vertex_c
  );

endinterface
`default_nettype wire

// File: rtl/tri_slot_buf.sv
`default_nettype none
// ============================================================================
// Module : tri_slot_buf
// Brief  : Two-slot triangle store, word-granular write, whole-triangle read.
// Rev    : 1.0 - initial release
// ============================================================================
module tri_slot_buf
  import tri_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic             i_wr_slot,
  input  logic [IDX_W-1:0] i_wr_word,
  input  coord_t           i_wr_data,
  input  logic             i_rd_slot,
  output triangle_t        o_rd_tri
);

  coord_t r_mem [2][NUM_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          r_mem[s][w] <= '0;
        end
      end
    end else if (i_wr_en && (i_wr_word <= LAST_IDX)) begin
      r_mem[i_wr_slot][i_wr_word] <= i_wr_data;
    end
  end

  // Word order in the stream is ax,ay,az,bx,...,cz.
  always_comb begin
    o_rd_tri = '0;
    for (int j = 0; j < 3; j++) begin
      o_rd_tri.a[j] = r_mem[i_rd_slot][j];
      o_rd_tri.b[j] = r_mem[i_rd_slot][j+3];
      o_rd_tri.c[j] = r_mem[i_rd_slot][j+6];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tri_assembler.sv
`default_nettype none
// ============================================================================
// Module : tri_assembler
// Brief  : Frames a serial coordinate stream into double-buffered triangles.
// Rev    : 1.0 - initial release
// ============================================================================
module tri_assembler
  import tri_pkg::*;
#(
  parameter int WII = PKG_WII,
  parameter int WIF = PKG_WIF
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_assembler_if.slave    bus,
  input  logic              flush,
  output logic              sync_err,
  output logic [15:0]       tri_count
);

  generate
    if ((WII != PKG_WII) || (WIF != PKG_WIF)) begin : g_param_check
      $error("tri_assembler: WII/WIF must match tri_pkg coordinate width");
    end
  endgenerate

  fill_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_word_idx, w_word_idx_nxt;
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0]       r_count, w_count_nxt;
  logic             r_tri_valid;
  logic             r_sync_err, w_sync_err_nxt;
  logic [15:0]      r_tri_count;
  logic             w_accept, w_pop, w_commit, w_wr_en;
  logic [IDX_W-1:0] w_wr_word;
  triangle_t        w_rd_tri;

  // Depends only on registered occupancy and flush, never on tri_ready.
  assign bus.in_ready = (r_count != 2'd2) && !flush;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_pop        = r_tri_valid && bus.tri_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_idx_nxt = r_word_idx;
    w_wr_en        = 1'b0;
    w_wr_word      = r_word_idx;
    w_sync_err_nxt = 1'b0;
    w_commit       = 1'b0;
    w_count_nxt    = r_count;

    if (w_accept) begin
      if (bus.in_sop) begin
        // A start word always opens a new frame; in FILL it drops the partial.
        w_wr_en        = 1'b1;
        w_wr_word      = '0;
        w_word_idx_nxt = IDX_W'(1);
        w_state_nxt    = S_FILL;
        w_sync_err_nxt = (r_state == S_FILL);
      end else if (r_state == S_IDLE) begin
        w_sync_err_nxt = 1'b1;
      end else begin
        w_wr_en = 1'b1;
        if (r_word_idx == LAST_IDX) begin
          w_commit       = 1'b1;
          w_word_idx_nxt = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_word_idx_nxt = r_word_idx + IDX_W'(1);
        end
      end
    end

    case ({w_commit, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase

    if (flush) begin
      w_state_nxt    = S_IDLE;
      w_word_idx_nxt = '0;
      w_count_nxt    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx  <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_tri_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_tri_count <= 16'd0;
    end else begin
      r_word_idx  <= w_word_idx_nxt;
      r_count     <= w_count_nxt;
      r_tri_valid <= (w_count_nxt != 2'd0);
      r_sync_err  <= w_sync_err_nxt;
      if (w_pop) begin
        r_tri_count <= r_tri_count + 16'd1;
      end
      if (flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_commit) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end
  end

  tri_slot_buf u_slot_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_slot (r_wr_ptr),
    .i_wr_word (w_wr_word),
    .i_wr_data (bus.in_data),
    .i_rd_slot (r_rd_ptr),
    .o_rd_tri  (w_rd_tri)
  );

  assign bus.tri_valid = r_tri_valid;
  assign bus.vertex_a  = w_rd_tri.a;
  assign bus.vertex_b  = w_rd_tri.b;
  assign bus.vertex_c  = w_rd_tri.c;
  assign sync_err      = r_sync_err;
  assign tri_count     = r_tri_count;

endmodule
`default_nettype wire
